// File: rtl/bcd_serial_addsub_pkg.sv
// Shared definitions for the digit-serial BCD adder/subtractor: digit width,
// FSM state encoding and a helper to pull one BCD digit out of a packed operand.
package bcd_pkg;

   localparam int BCD_W      = 4;
   localparam int MAX_DIGITS = 32;
   localparam int MAX_W      = BCD_W * MAX_DIGITS;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   // Operands narrower than MAX_W are zero-extended by the caller first.
   function automatic logic [BCD_W-1:0] getDigit(input logic [MAX_W-1:0] vec, input int idx);
      return vec[idx*BCD_W +: BCD_W];
   endfunction

endpackage

// File: rtl/bcd_serial_addsub_if.sv
// Start/busy/done handshake and operand/result bus of the serial BCD adder.
// The requester uses the master modport, the arithmetic unit the slave modport.
interface bcd_serial_addsub_if #(
   parameter int DIGITS = 4
);
   import bcd_pkg::*;

   logic                      start;
   logic                      sub;
   logic [BCD_W*DIGITS-1:0]   a;
   logic [BCD_W*DIGITS-1:0]   b;
   logic                      busy;
   logic                      done;
   logic [BCD_W*DIGITS-1:0]   sum;
   logic                      cout;
   logic                      err;

   modport master (
      output start, sub, a, b,
      input  busy, done, sum, cout, err
   );

   modport slave (
      input  start, sub, a, b,
      output busy, done, sum, cout, err
   );

endinterface

// File: rtl/bcd_serial_addsub_digit_add.sv
// Single-digit BCD add/subtract slice: subtraction adds the 9's complement of b,
// with the caller seeding the carry to form the 10's complement.
module bcd_digit_add
   import bcd_pkg::*;
(
   input  logic [BCD_W-1:0] a_i,
   input  logic [BCD_W-1:0] b_i,
   input  logic             cin_i,
   input  logic             sub_i,
   output logic [BCD_W-1:0] digit_o,
   output logic             cout_o,
   output logic             invalid_o
);

   logic [BCD_W-1:0] bEff;
   logic [BCD_W:0]   rawSum;

   // An invalid b digit wraps in 4 bits; the result is flagged via invalid_o anyway.
   always_comb begin
      bEff      = sub_i ? (4'd9 - b_i) : b_i;
      rawSum    = 5'(a_i) + 5'(bEff) + 5'(cin_i);
      invalid_o = (a_i > 4'd9) | (b_i > 4'd9);
      if (rawSum > 5'd9) begin
         digit_o = 4'(rawSum - 5'd10);
         cout_o  = 1'b1;
      end else begin
         digit_o = rawSum[BCD_W-1:0];
         cout_o  = 1'b0;
      end
   end

endmodule

// File: rtl/bcd_serial_addsub.sv
// Digit-serial BCD adder/subtractor: processes one digit per clock, LSD first,
// and reports the decimal carry (or no-borrow) and an invalid-digit flag at done.
module bcd_serial_addsub
   import bcd_pkg::*;
#(
   parameter int DIGITS = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   bcd_serial_addsub_if.slave   bus
);

   localparam int W     = BCD_W * DIGITS;
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

   state_t           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [W-1:0]     opA_q, opA_d;
   logic [W-1:0]     opB_q, opB_d;
   logic [W-1:0]     sum_q, sum_d;
   logic             sub_q, sub_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic             err_q, err_d;

   logic [MAX_W-1:0] opAExt, opBExt;
   logic [BCD_W-1:0] digA, digB, digSum;
   logic             digCout, digInvalid;

   always_comb begin
      opAExt          = '0;
      opBExt          = '0;
      opAExt[W-1:0]   = opA_q;
      opBExt[W-1:0]   = opB_q;
      digA            = getDigit(opAExt, int'(idx_q));
      digB            = getDigit(opBExt, int'(idx_q));
   end

   bcd_digit_add digitAdd (
      .a_i       (digA),
      .b_i       (digB),
      .cin_i     (carry_q),
      .sub_i     (sub_q),
      .digit_o   (digSum),
      .cout_o    (digCout),
      .invalid_o (digInvalid)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         opA_q   <= '0;
         opB_q   <= '0;
         sum_q   <= '0;
         sub_q   <= 1'b0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         opA_q   <= opA_d;
         opB_q   <= opB_d;
         sum_q   <= sum_d;
         sub_q   <= sub_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         err_q   <= err_d;
      end
   end

   // DONE accepts a new start exactly like IDLE so jobs can run back to back.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      opA_d   = opA_q;
      opB_d   = opB_q;
      sum_d   = sum_q;
      sub_d   = sub_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      err_d   = err_q;
      case (state_q)
         IDLE, DONE: begin
            if (bus.start) begin
               state_d = CALC;
               opA_d   = bus.a;
               opB_d   = bus.b;
               sub_d   = bus.sub;
               carry_d = bus.sub;
               idx_d   = '0;
               sum_d   = '0;
               cout_d  = 1'b0;
               err_d   = 1'b0;
            end else begin
               state_d = IDLE;
            end
         end
         CALC: begin
            for (int i = 0; i < DIGITS; i++) begin
               if (idx_q == IDX_W'(i)) begin
                  sum_d[i*BCD_W +: BCD_W] = digSum;
               end
            end
            carry_d = digCout;
            err_d   = err_q | digInvalid;
            if (idx_q == LAST_IDX) begin
               state_d = DONE;
               cout_d  = digCout;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.busy = (state_q == CALC);
   assign bus.done = (state_q == DONE);
   assign bus.sum  = sum_q;
   assign bus.cout = cout_q;
   assign bus.err  = err_q;

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Directed bench for bcd_serial_addsub: a 4-digit instance for arithmetic and handshake
// cases and a 1-digit instance swept exhaustively with start held high.
module tb_bcd_serial_addsub;

   typedef struct packed {
      logic [15:0] sum;
      logic        cout;
      logic        err;
   } expT;

   logic clk = 1'b0;
   logic rst;

   bcd_serial_addsub_if #(.DIGITS(4)) bus4 ();
   bcd_serial_addsub_if #(.DIGITS(1)) bus1 ();

   bcd_serial_addsub #(.DIGITS(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
   bcd_serial_addsub #(.DIGITS(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

   expT exp4Q[$];
   expT exp1Q[$];
   int  checkCount = 0;
   int  passCount  = 0;
   int  failCount  = 0;

   always #5 clk = ~clk;

   // Decimal reference: convert to integers, do the arithmetic, convert back.
   function automatic expT refModel(input int digits, input logic [15:0] a, input logic [15:0] b,
                                    input logic sub);
      expT         e;
      int          av, bv, modv, r;
      logic [3:0]  da, db;
      av = 0; bv = 0; modv = 1;
      e  = '0;
      for (int i = digits - 1; i >= 0; i--) begin
         da = a[i*4 +: 4];
         db = b[i*4 +: 4];
         if (da > 4'd9 || db > 4'd9) e.err = 1'b1;
         av   = av * 10 + int'(da);
         bv   = bv * 10 + int'(db);
         modv = modv * 10;
      end
      if (sub) begin
         r      = av - bv + modv;
         e.cout = (av >= bv);
      end else begin
         r      = av + bv;
         e.cout = (r >= modv);
      end
      r = r % modv;
      for (int i = 0; i < digits; i++) begin
         e.sum[i*4 +: 4] = 4'(r % 10);
         r = r / 10;
      end
      return e;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checkCount++;
      assert (obs === expv) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0h required %0h", tag, obs, expv);
      end
   endtask

   task automatic waitCycle();
      @(posedge clk);
      #1;
   endtask

   // Launch a 4-digit job; returns one cycle after the accepting edge (cycle 1).
   task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic sub);
      bus4.a     = a;
      bus4.b     = b;
      bus4.sub   = sub;
      bus4.start = 1'b1;
      exp4Q.push_back(refModel(4, a, b, sub));
      waitCycle();
      bus4.start = 1'b0;
   endtask

   task automatic waitDone4(input string tag, output int cycles, output int busyCycles);
      cycles     = 1;
      busyCycles = 0;
      while (!bus4.done && cycles < 20) begin
         if (bus4.busy) busyCycles++;
         waitCycle();
         cycles++;
      end
      checkOutput({tag, "_done"}, 32'(bus4.done), 32'd1);
   endtask

   task automatic compareResult4(input string tag);
      expT e;
      checkOutput({tag, "_sbNonEmpty"}, 32'(exp4Q.size() != 0), 32'd1);
      if (exp4Q.size() != 0) begin
         e = exp4Q.pop_front();
         checkOutput({tag, "_err"}, 32'(bus4.err), 32'(e.err));
         if (!e.err) begin
            checkOutput({tag, "_sum"}, 32'(bus4.sum), 32'(e.sum));
            checkOutput({tag, "_cout"}, 32'(bus4.cout), 32'(e.cout));
         end
      end
   endtask

   task automatic compareResult1(input string tag);
      expT e;
      checkOutput({tag, "_sbNonEmpty"}, 32'(exp1Q.size() != 0), 32'd1);
      if (exp1Q.size() != 0) begin
         e = exp1Q.pop_front();
         checkOutput({tag, "_sum"}, 32'(bus1.sum), 32'(e.sum[3:0]));
         checkOutput({tag, "_cout"}, 32'(bus1.cout), 32'(e.cout));
         checkOutput({tag, "_err"}, 32'(bus1.err), 32'(e.err));
      end
   endtask

   initial begin
      int          cycles, busyCycles;
      logic        doneSeen;
      logic [15:0] caseA [5];
      logic [15:0] caseB [5];
      logic        caseS [5];

      caseA = '{16'h9999, 16'h0000, 16'h5000, 16'h0001, 16'h4321};
      caseB = '{16'h0001, 16'h0000, 16'h1234, 16'h0002, 16'h4321};
      caseS = '{1'b0,     1'b0,     1'b1,     1'b1,     1'b1};

      rst        = 1'b1;
      bus4.start = 1'b0; bus4.sub = 1'b0; bus4.a = '0; bus4.b = '0;
      bus1.start = 1'b0; bus1.sub = 1'b0; bus1.a = '0; bus1.b = '0;
      repeat (3) waitCycle();
      rst = 1'b0;
      checkOutput("reset_busy", 32'(bus4.busy), 32'd0);
      checkOutput("reset_done", 32'(bus4.done), 32'd0);
      checkOutput("reset_sum",  32'(bus4.sum),  32'd0);
      checkOutput("reset_cout", 32'(bus4.cout), 32'd0);
      checkOutput("reset_err",  32'(bus4.err),  32'd0);
      checkOutput("reset_busy1", 32'(bus1.busy), 32'd0);

      $display("[TB] 4-digit latency and arithmetic cases");
      applyStimulus(16'h1234, 16'h5678, 1'b0);
      waitDone4("add1234", cycles, busyCycles);
      checkOutput("add1234_latency", 32'(cycles), 32'd5);
      checkOutput("add1234_busyCycles", 32'(busyCycles), 32'd4);
      compareResult4("add1234");
      waitCycle();
      checkOutput("add1234_doneOneCycle", 32'(bus4.done), 32'd0);
      checkOutput("add1234_sumHeld", 32'(bus4.sum), 32'h6912);

      for (int i = 0; i < 5; i++) begin
         applyStimulus(caseA[i], caseB[i], caseS[i]);
         waitDone4("table", cycles, busyCycles);
         compareResult4($sformatf("table%0d", i));
         waitCycle();
      end

      $display("[TB] invalid digit then recovery");
      applyStimulus(16'h00A0, 16'h0001, 1'b0);
      waitDone4("invalid", cycles, busyCycles);
      compareResult4("invalid");
      waitCycle();
      applyStimulus(16'h0042, 16'h0017, 1'b0);
      waitDone4("recover", cycles, busyCycles);
      compareResult4("recover");
      waitCycle();

      $display("[TB] start while busy is ignored");
      applyStimulus(16'h2468, 16'h1357, 1'b0);
      bus4.a = 16'h9999; bus4.b = 16'h9999; bus4.sub = 1'b1; bus4.start = 1'b1;
      waitCycle();
      bus4.start = 1'b0;
      waitDone4("ignored", cycles, busyCycles);
      compareResult4("ignored");
      waitCycle();

      $display("[TB] reset mid-operation");
      applyStimulus(16'h1111, 16'h2222, 1'b0);
      void'(exp4Q.pop_back());
      waitCycle();
      rst = 1'b1;
      waitCycle();
      checkOutput("abort_busy", 32'(bus4.busy), 32'd0);
      checkOutput("abort_done", 32'(bus4.done), 32'd0);
      checkOutput("abort_sum",  32'(bus4.sum),  32'd0);
      checkOutput("abort_cout", 32'(bus4.cout), 32'd0);
      checkOutput("abort_err",  32'(bus4.err),  32'd0);
      rst      = 1'b0;
      doneSeen = 1'b0;
      repeat (8) begin
         waitCycle();
         doneSeen = doneSeen | bus4.done;
      end
      checkOutput("abort_noDone", 32'(doneSeen), 32'd0);

      $display("[TB] 1-digit exhaustive sweep, start held high");
      bus1.start = 1'b1;
      for (int s = 0; s < 2; s++) begin
         for (int x = 0; x < 10; x++) begin
            for (int y = 0; y < 10; y++) begin
               bus1.a   = 4'(x);
               bus1.b   = 4'(y);
               bus1.sub = s[0];
               exp1Q.push_back(refModel(1, {12'h000, 4'(x)}, {12'h000, 4'(y)}, s[0]));
               waitCycle();
               checkOutput("d1_busy", 32'(bus1.busy), 32'd1);
               waitCycle();
               checkOutput("d1_done", 32'(bus1.done), 32'd1);
               compareResult1($sformatf("d1_s%0d_a%0d_b%0d", s, x, y));
            end
         end
      end
      bus1.start = 1'b0;
      waitCycle();
      checkOutput("d1_idleAfter", 32'({bus1.busy, bus1.done}), 32'd0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
